k_mem_access_ctrl: RTL
======================

K_MEM_ACCESS_CTRL -- requirements
Module: k_mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of the request.
REQ-002 SHALL have parameter RAM_AW, default ADDR_W-2, word-address width on the RAM side.
REQ-003 SHALL have port K_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port K_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port K_req_valid  input  1  pipeline presents a load/store.
REQ-006 SHALL have port K_req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port K_req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL have port K_req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have port K_req_addr  input  ADDR_W  byte address (ALU result).
REQ-010 SHALL have port K_req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port K_stall  output  1  pipeline must hold request inputs stable.
REQ-012 SHALL have port K_rsp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port K_rsp_rdata  output  32  extended load result.
REQ-014 SHALL have port K_misalign  output  1  alignment fault, valid with K_rsp_valid.
REQ-015 SHALL have ports K_ram_req (output, 1), K_ram_we (output, 1), K_ram_be (output, 4), K_ram_addr (output, RAM_AW), K_ram_wdata (output, 32), K_ram_ack (input, 1) and K_ram_rdata (input, 32), forming the data-RAM handshake.

Function
REQ-016 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-017 SHALL move IDLE -> BUSY when K_req_valid=1, latching address, size, write, unsigned and wdata.
REQ-018 SHALL drive K_stall = (IDLE & K_req_valid) | BUSY; K_stall SHALL be 0 in RESP.
REQ-019 SHALL hold all K_ram_* request outputs registered and constant in BUSY, with K_ram_req=1, until K_ram_ack=1; the ack cycle moves BUSY -> RESP.
REQ-020 SHALL permit an ack in the first BUSY cycle, giving minimum latency of 3 cycles from request to K_rsp_valid.
REQ-021 SHALL assert K_rsp_valid for exactly one cycle in RESP, for loads and stores alike.
REQ-022 SHALL ignore K_req_valid in RESP; the next request is accepted only in IDLE.
REQ-023 SHALL use little-endian lanes: byte be=0001<<addr[1:0]; half be=0011<<{addr[1],0}; word be=1111.
REQ-024 SHALL replicate store data (byte x4, half x2) on K_ram_wdata.
REQ-025 SHALL capture K_ram_rdata at ack, select the lane, extend per K_req_unsigned, and register it into K_rsp_rdata; stores SHALL leave K_rsp_rdata unchanged.
REQ-026 SHALL drive K_ram_addr = addr[ADDR_W-1:2].

Reset
REQ-027 SHALL on K_rst_n=0 immediately force state to IDLE and drive K_ram_req, K_ram_we, K_ram_be, K_ram_addr, K_ram_wdata, K_rsp_valid, K_rsp_rdata and K_misalign to 0, including mid-access, abandoning any in-flight RAM transaction.

Configuration
REQ-028 SHALL, with K_MEM_ALIGN_CHECK_EN defined, detect half accesses with addr[0]=1 and word accesses with addr[1:0]!=0, skip BUSY (no K_ram_req), go IDLE -> RESP, pulse K_misalign=1 with K_rsp_valid, and leave K_rsp_rdata unchanged.
REQ-029 SHALL, without K_MEM_ALIGN_CHECK_EN, tie K_misalign to 0 and silently ignore the offending low address bits per REQ-023.

Structure
REQ-030 SHALL place the size encodings, the FSM state enum and the byte-enable constants in shared package k_mem_pkg.
REQ-031 SHALL contain one combinational sub-module, k_load_align, for lane select and extension.

Verification
REQ-032 SHALL cover this case: sw addr 0x10, wdata 0xDEADBEEF, ack after 2 cycles -> be=1111, ram_addr=0x4, K_stall high 3 cycles, rsp_valid pulse.
REQ-033 SHALL cover this case: lb addr 0x13, ram_rdata 0x80FF1234, signed -> rsp_rdata 0xFFFFFF80; the same with lbu -> 0x00000080.
REQ-034 SHALL cover this case: sh addr 0x22, wdata 0x0000ABCD -> be=1100, ram_wdata 0xABCDABCD.
REQ-035 SHALL cover this case: with the macro, lw addr 0x06 -> no K_ram_req, K_misalign=1 with rsp_valid 2 cycles after request; without the macro, be=1111 and ram_addr=0x1.
REQ-036 SHALL cover this case: K_rst_n low during BUSY -> K_ram_req drops the same cycle, no rsp_valid, next request completes normally.
REQ-037 SHALL cover this case: ack held low 20 cycles -> K_stall held high 21 cycles and K_ram_* outputs stable throughout.

Source files
------------

// File: rtl/k_mem_pkg.sv
// Shared definitions for the data-memory access controller: access-size
// encodings, controller state encoding, lane byte-enable constants and the
// lane helpers used when a request is accepted.
package k_mem_pkg;

   // Access size as presented by the pipeline; 2'b11 behaves as a word
   typedef enum logic [1:0] {
      SIZE_BYTE   = 2'b00,
      SIZE_HALF   = 2'b01,
      SIZE_WORD   = 2'b10,
      SIZE_WORD_X = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;

   // Lane-0 byte enables, shifted up to the addressed lane
   localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
   localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
   localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

   // Little-endian byte enables; offending low bits of halves are dropped
   function automatic logic [BE_W-1:0] byte_en(input size_e size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: return BE_BYTE << off;
         SIZE_HALF: return BE_HALF << {off[1], 1'b0};
         default:   return BE_WORD;
      endcase
   endfunction

   // Replicate narrow store data across every lane so the RAM sees it on any lane
   function automatic logic [DATA_W-1:0] store_data(input size_e size, input logic [DATA_W-1:0] wd);
      case (size)
         SIZE_BYTE: return {4{wd[7:0]}};
         SIZE_HALF: return {2{wd[15:0]}};
         default:   return wd;
      endcase
   endfunction

   // Natural-alignment test: halves on even, words on multiple-of-4 addresses
   function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return off[0];
         default:   return (off != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/k_load_align.sv
// Load lane select and extension (purely combinational).
//   size        : latched access size
//   offset      : latched byte offset addr[1:0]
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   word        : raw 32-bit RAM read data
//   data_c      : right-justified, extended load result
module k_load_align
   import k_mem_pkg::*;
(
   input  size_e             size,
   input  logic [1:0]        offset,
   input  logic              is_unsigned,
   input  logic [DATA_W-1:0] word,
   output logic [DATA_W-1:0] data_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sign_bit;

   always_comb begin
      byte_sel = 8'(word >> {offset, 3'b000});
      half_sel = offset[1] ? word[31:16] : word[15:0];
      sign_bit = 1'b0;
      data_c   = word;
      case (size)
         SIZE_BYTE: begin
            sign_bit = ~is_unsigned & byte_sel[7];
            data_c   = {{24{sign_bit}}, byte_sel};
         end
         SIZE_HALF: begin
            sign_bit = ~is_unsigned & half_sel[15];
            data_c   = {{16{sign_bit}}, half_sel};
         end
         default: data_c = word;
      endcase
   end

endmodule

// File: rtl/k_mem_access_ctrl.sv
// Load/store unit front end: accepts one pipeline memory request at a time,
// runs a req/ack handshake with the data RAM and returns a one-cycle
// completion pulse with the aligned, extended load data.
// Optional build macro K_MEM_ALIGN_CHECK_EN: misaligned half/word accesses
// are not sent to the RAM and complete with K_misalign=1 instead.
// Ports:
//   K_clk, K_rst_n                       clock, async active-low reset
//   K_req_valid/write/size/unsigned/addr/wdata   pipeline request
//   K_stall                              pipeline must hold the request
//   K_rsp_valid, K_rsp_rdata, K_misalign completion
//   K_ram_req/we/be/addr/wdata, K_ram_ack, K_ram_rdata   data-RAM handshake
module k_mem_access_ctrl
   import k_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned RAM_AW = ADDR_W - 2
) (
   input  logic              K_clk,
   input  logic              K_rst_n,
   input  logic              K_req_valid,
   input  logic              K_req_write,
   input  logic [1:0]        K_req_size,
   input  logic              K_req_unsigned,
   input  logic [ADDR_W-1:0] K_req_addr,
   input  logic [DATA_W-1:0] K_req_wdata,
   output logic              K_stall,
   output logic              K_rsp_valid,
   output logic [DATA_W-1:0] K_rsp_rdata,
   output logic              K_misalign,
   output logic              K_ram_req,
   output logic              K_ram_we,
   output logic [BE_W-1:0]   K_ram_be,
   output logic [RAM_AW-1:0] K_ram_addr,
   output logic [DATA_W-1:0] K_ram_wdata,
   input  logic              K_ram_ack,
   input  logic [DATA_W-1:0] K_ram_rdata
);

   state_e            state;
   size_e             size_q;
   logic [1:0]        off_q;
   logic              uns_q;
   logic              misalign_q;
   logic              mis_c;
   size_e             req_size_c;
   logic [DATA_W-1:0] load_data_c;

   assign req_size_c = size_e'(K_req_size);

`ifdef K_MEM_ALIGN_CHECK_EN
   assign mis_c = is_misaligned(req_size_c, K_req_addr[1:0]);
`else
   assign mis_c = 1'b0;
`endif

   // Combinational so the pipeline freezes in the same cycle it presents a request
   assign K_stall    = ((state == ST_IDLE) && K_req_valid) || (state == ST_BUSY);
   assign K_misalign = misalign_q;

   k_load_align u_load_align (
      .size        (size_q),
      .offset      (off_q),
      .is_unsigned (uns_q),
      .word        (K_ram_rdata),
      .data_c      (load_data_c)
   );

   // Controller FSM with registered RAM and response outputs
   always_ff @(posedge K_clk or negedge K_rst_n) begin
      if (!K_rst_n) begin
         state       <= ST_IDLE;
         size_q      <= SIZE_BYTE;
         off_q       <= 2'b00;
         uns_q       <= 1'b0;
         misalign_q  <= 1'b0;
         K_rsp_valid <= 1'b0;
         K_rsp_rdata <= '0;
         K_ram_req   <= 1'b0;
         K_ram_we    <= 1'b0;
         K_ram_be    <= '0;
         K_ram_addr  <= '0;
         K_ram_wdata <= '0;
      end else begin
         K_rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (K_req_valid) begin
                  size_q <= req_size_c;
                  off_q  <= K_req_addr[1:0];
                  uns_q  <= K_req_unsigned;
                  if (mis_c) begin
                     // Faulting access never reaches the RAM
                     state       <= ST_RESP;
                     K_rsp_valid <= 1'b1;
                     misalign_q  <= 1'b1;
                  end else begin
                     state       <= ST_BUSY;
                     K_ram_req   <= 1'b1;
                     K_ram_we    <= K_req_write;
                     K_ram_be    <= byte_en(req_size_c, K_req_addr[1:0]);
                     K_ram_addr  <= RAM_AW'(K_req_addr[ADDR_W-1:2]);
                     K_ram_wdata <= store_data(req_size_c, K_req_wdata);
                  end
               end
            end
            ST_BUSY: begin
               if (K_ram_ack) begin
                  state       <= ST_RESP;
                  K_ram_req   <= 1'b0;
                  K_rsp_valid <= 1'b1;
                  if (!K_ram_we) begin
                     K_rsp_rdata <= load_data_c;
                  end
               end
            end
            ST_RESP: begin
               // Requests are not sampled here; next acceptance is in IDLE
               state      <= ST_IDLE;
               misalign_q <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
